// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-control types for the RV64 core: hazard FSM state encoding,
// register-zero index and the default performance counter width.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_BR_BUBBLE  = 2'd2,
    HZ_MEM_WAIT   = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         CNT_W_DEFAULT = 32;

endpackage

// File: rtl/hzd_sat_counter.sv
// Saturating up-counter for hazard statistics; holds at all-ones instead of
// wrapping. Synchronous active-high reset.
module hzd_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV64 pipeline: load-use stalls, taken-branch
// redirects with optional extra bubbles, and DMEM freezes. HZD_PERF_CNT_EN adds counters.
//
// state         | meaning
// HZ_RUN        | normal issue, all hazards evaluated
// HZ_LOAD_STALL | cycle after a load-use bubble; load-use not re-checked
// HZ_BR_BUBBLE  | extra IF/ID flush cycles after a taken branch
// HZ_MEM_WAIT   | pipeline frozen on dmem_busy; ret_state says where to resume
module hazard_ctrl_unit
  import riscv_pipe_pkg::*;
#(
  parameter int FLUSH_EXTRA = 0,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] BUB_INIT = (FLUSH_EXTRA > 0) ? 3'(FLUSH_EXTRA - 1) : 3'd0;

  hz_state_e  state, state_nxt;
  hz_state_e  ret_state, ret_nxt;
  hz_state_e  eff_state;
  logic [2:0] bub_cnt, bub_nxt;
  logic       load_use;

  assign load_use = idex_memread && (idex_rd != REG_ZERO) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HZ_RUN;
      ret_state <= HZ_RUN;
      bub_cnt   <= 3'd0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      bub_cnt   <= bub_nxt;
    end
  end

  // A release cycle in MEM_WAIT behaves exactly like the saved state would.
  always_comb begin
    state_nxt     = state;
    ret_nxt       = ret_state;
    bub_nxt       = bub_cnt;
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_hold     = 1'b0;
    eff_state     = (state == HZ_MEM_WAIT) ? ret_state : state;

    if (reset) begin
      state_nxt = HZ_RUN;
      ret_nxt   = HZ_RUN;
      bub_nxt   = 3'd0;
    end else if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_nxt  = HZ_MEM_WAIT;
      ret_nxt    = (eff_state == HZ_BR_BUBBLE) ? HZ_BR_BUBBLE : HZ_RUN;
    end else if (eff_state == HZ_BR_BUBBLE) begin
      ifid_flush = 1'b1;
      if (bub_cnt == 3'd0) begin
        state_nxt = HZ_RUN;
      end else begin
        bub_nxt   = bub_cnt - 3'd1;
        state_nxt = HZ_BR_BUBBLE;
      end
    end else if (ex_branch_taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      if (FLUSH_EXTRA > 0) begin
        state_nxt = HZ_BR_BUBBLE;
        bub_nxt   = BUB_INIT;
      end else begin
        state_nxt = HZ_RUN;
      end
    end else if (load_use && (eff_state == HZ_RUN)) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_nxt  = HZ_LOAD_STALL;
    end else begin
      state_nxt = HZ_RUN;
    end
  end

`ifdef HZD_PERF_CNT_EN
  logic stall_inc, flush_inc;

  // pc_sel_branch only rises on a redirect; any other idex_flush is a load-use bubble.
  assign flush_inc = pc_sel_branch;
  assign stall_inc = idex_flush && !pc_sel_branch;

  hzd_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .value (stall_cnt)
  );

  hzd_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .value (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed hazard scenarios followed by
// random traffic, checked against a bubble-count reference model.
module tb_hazard_ctrl_unit;

  localparam int FE = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          idex_memread = 1'b0;
  logic [4:0]    idex_rd = '0;
  logic [4:0]    ifid_rs1 = '0;
  logic [4:0]    ifid_rs2 = '0;
  logic          ifid_uses_rs2 = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          dmem_busy = 1'b0;
  logic          pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_flush, pipe_hold;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl_unit #(.FLUSH_EXTRA(FE), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .idex_memread    (idex_memread),
    .idex_rd         (idex_rd),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_uses_rs2   (ifid_uses_rs2),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_write        (pc_write),
    .pc_sel_branch   (pc_sel_branch),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pipe_hold       (pipe_hold),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic          chk_cnt;
    logic [CW-1:0] stall, flush;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: remaining bubbles, whether last cycle issued a load-use stall, event tallies.
  int      bub_left = 0;
  bit      just_stalled = 1'b0;
  longint  n_stall = 0;
  longint  n_flush = 0;

`ifdef HZD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic br, input logic bz);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    reset = r; idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_uses_rs2 = u2; ex_branch_taken = br; dmem_busy = bz;
    lu = mr && (rd != 5'd0) && ((rd == rs1) || (u2 && (rd == rs2)));
    e.pc_write = 1'b1; e.pc_sel_branch = 1'b0; e.ifid_write = 1'b1;
    e.ifid_flush = 1'b0; e.idex_flush = 1'b0; e.pipe_hold = 1'b0;
    e.chk_cnt = !r;
    e.stall = CNT_EN ? CW'(n_stall) : '0;
    e.flush = CNT_EN ? CW'(n_flush) : '0;
    if (r) begin
      bub_left = 0; just_stalled = 1'b0; n_stall = 0; n_flush = 0;
    end else if (bz) begin
      e.pc_write = 1'b0; e.ifid_write = 1'b0; e.pipe_hold = 1'b1;
      just_stalled = 1'b0;
    end else if (bub_left > 0) begin
      e.ifid_flush = 1'b1;
      bub_left--;
      just_stalled = 1'b0;
    end else if (br) begin
      e.pc_sel_branch = 1'b1; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      n_flush++;
      bub_left = FE;
      just_stalled = 1'b0;
    end else if (lu && !just_stalled) begin
      e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_flush = 1'b1;
      n_stall++;
      just_stalled = 1'b1;
    end else begin
      just_stalled = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic void chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc_write", CW'(pc_write), CW'(e.pc_write));
      chk("pc_sel_branch", CW'(pc_sel_branch), CW'(e.pc_sel_branch));
      chk("ifid_write", CW'(ifid_write), CW'(e.ifid_write));
      chk("ifid_flush", CW'(ifid_flush), CW'(e.ifid_flush));
      chk("idex_flush", CW'(idex_flush), CW'(e.idex_flush));
      chk("pipe_hold", CW'(pipe_hold), CW'(e.pipe_hold));
      if (e.chk_cnt) begin
        chk("stall_cnt", stall_cnt, e.stall);
        chk("flush_cnt", flush_cnt, e.flush);
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // load-use on rs1, operands still presented during the stall cycle
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    // x0 destination never stalls
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // rs2 match only counts when rs2 is used
    step(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(2);
    // taken branch with two extra bubbles
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // branch and load-use together
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    idle(3);
    // busy for three cycles inside the bubble window
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // reset while in the load stall
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      step(1'b0 || ($urandom_range(99) < 2), 1'($urandom_range(1)), 5'($urandom_range(3)),
           5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
           1'($urandom_range(99) < 15), 1'($urandom_range(99) < 15));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
